// File: rtl/ray_scene_dispatcher_pkg.sv
// rtrt_pkg: shared types for the ray scene dispatcher and its intersector link.
package rtrt_pkg;

    localparam int DIST_W = 36;

    typedef logic signed [15:0] coord_t;
    typedef coord_t [2:0] vec3_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] r;
    } sphere_t;

    typedef enum logic [3:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_EVAL0,
        ST_EVAL1,
        ST_NEXT,
        ST_FIN
    } disp_state_t;

endpackage

// File: rtl/ray_scene_dispatcher_if.sv
// isect_if: job handshake between the dispatcher (master) and the intersector (slave).
interface isect_if;
    import rtrt_pkg::*;

    logic          enable;
    sphere_t       sphere;
    vec3_t         p0;
    vec3_t         p1;
    logic          bounded;
    logic [3:0]    threshold;
    logic          ready;
    logic          collide;
    vec3_t         pint0;
    vec3_t         pint1;

    modport master (
        output enable, sphere, p0, p1, bounded, threshold,
        input  ready, collide, pint0, pint1
    );

    modport slave (
        input  enable, sphere, p0, p1, bounded, threshold,
        output ready, collide, pint0, pint1
    );

endinterface

// File: rtl/ray_scene_dispatcher_dist_sq.sv
// dist_sq: squared euclidean distance between two 16-bit signed points, exact in 36 bits.
module dist_sq
    import rtrt_pkg::*;
(
    input  vec3_t             i_a,
    input  vec3_t             i_b,
    output logic [DIST_W-1:0] o_dist
);

    logic signed [16:0] w_diff [3];
    logic signed [33:0] w_sq   [3];

    // Per-axis difference is widened to 17 bits so that spans up to 65535 stay exact.
    for (genvar g = 0; g < 3; g++) begin : g_axis
        assign w_diff[g] = {i_a[g][15], i_a[g]} - {i_b[g][15], i_b[g]};
        assign w_sq[g]   = w_diff[g] * w_diff[g];
    end

    assign o_dist = {2'b00, w_sq[0]} + {2'b00, w_sq[1]} + {2'b00, w_sq[2]};

endmodule

// File: rtl/ray_scene_dispatcher.sv
// ray_scene_dispatcher: walks the sphere table for one ray, issues one intersector
// job per sphere and keeps the hit point closest to the ray origin.
module ray_scene_dispatcher
    import rtrt_pkg::*;
#(
    parameter int         N_SPHERES = 8,
    parameter int         TIMEOUT   = 4096,
    parameter logic [3:0] THRESHOLD = 4'd2,
    parameter logic       BOUNDED   = 1'b1,
    localparam int        IDX_W     = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1
)(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  vec3_t            i_ray_p0,
    input  vec3_t            i_ray_p1,
    output logic [IDX_W-1:0] o_sph_addr,
    input  sphere_t          i_sph_data,
    isect_if.master          isect,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_hit_id,
    output vec3_t            o_hit_point,
    output logic             o_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPHERES - 1);

    disp_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    vec3_t             r_p0;
    vec3_t             r_p1;
    vec3_t             r_c0;
    vec3_t             r_c1;
    logic [DIST_W-1:0] r_best_d;
    logic [IDX_W-1:0]  r_best_id;
    vec3_t             r_best_pt;
    logic              r_best_valid;
    logic              r_enable;
    logic              r_busy;
    logic              r_done;
    logic              r_hit;
    logic [IDX_W-1:0]  r_hit_id;
    vec3_t             r_hit_pt;
    logic              r_err;

    vec3_t             w_eval_pt;
    logic [DIST_W-1:0] w_eval_d;
    logic              w_better;
    logic              w_timeout;
    logic              w_to_fin;

    // One distance unit serves both candidates; EVAL1 selects the second one.
    assign w_eval_pt = (r_state == ST_EVAL1) ? r_c1 : r_c0;

    dist_sq u_dist (
        .i_a    (w_eval_pt),
        .i_b    (r_p0),
        .o_dist (w_eval_d)
    );

    // Strict compare keeps the earlier candidate on a tie.
    assign w_better  = (w_eval_d < r_best_d);
    assign w_timeout = (r_state == ST_WAIT) && !isect.ready && (r_cnt == CNT_LAST);
    assign w_to_fin  = w_timeout || ((r_state == ST_NEXT) && (r_idx == LAST_IDX));

    // Dispatcher FSM with registered outputs; results are published on entry to FIN.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_FLUSH;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_p0         <= '0;
            r_p1         <= '0;
            r_c0         <= '0;
            r_c1         <= '0;
            r_best_d     <= '1;
            r_best_id    <= '0;
            r_best_pt    <= '0;
            r_best_valid <= 1'b0;
            r_enable     <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_id     <= '0;
            r_hit_pt     <= '0;
            r_err        <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_FLUSH: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (i_start) begin
                        r_p0         <= i_ray_p0;
                        r_p1         <= i_ray_p1;
                        r_idx        <= '0;
                        r_best_valid <= 1'b0;
                        r_best_d     <= '1;
                        r_err        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_enable <= 1'b1;
                    r_state  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (isect.ready) begin
                        if (isect.collide) begin
                            r_c0    <= isect.pint0;
                            r_c1    <= isect.pint1;
                            r_state <= ST_EVAL0;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_EVAL0, ST_EVAL1: begin
                    if (w_better) begin
                        r_best_d     <= w_eval_d;
                        r_best_id    <= r_idx;
                        r_best_pt    <= w_eval_pt;
                        r_best_valid <= 1'b1;
                    end
                    r_state <= (r_state == ST_EVAL0) ? ST_EVAL1 : ST_NEXT;
                end
                ST_NEXT: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= ST_FLUSH;
                end
            endcase
            if (w_to_fin) begin
                r_done   <= 1'b1;
                r_hit    <= r_best_valid;
                r_hit_id <= r_best_id;
                r_hit_pt <= r_best_pt;
            end
        end
    end

    assign o_sph_addr      = r_idx;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_hit           = r_hit;
    assign o_hit_id        = r_hit_id;
    assign o_hit_point     = r_hit_pt;
    assign o_err           = r_err;

    assign isect.enable    = r_enable;
    assign isect.sphere    = i_sph_data;
    assign isect.p0        = r_p0;
    assign isect.p1        = r_p1;
    assign isect.bounded   = BOUNDED;
    assign isect.threshold = THRESHOLD;

endmodule

// File: tb/tb_ray_scene_dispatcher.sv
// tb_ray_scene_dispatcher: directed bench with a behavioural intersector and a
// registered sphere ROM; expected results are hand-computed per vector.
module tb_ray_scene_dispatcher;
    import rtrt_pkg::*;

    localparam int NS = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    vec3_t      rayP0;
    vec3_t      rayP1;
    logic [1:0] sphAddr;
    sphere_t    sphData;
    logic       busy;
    logic       done;
    logic       hit;
    logic [1:0] hitId;
    vec3_t      hitPoint;
    logic       err;

    int checks = 0;
    int errors = 0;

    isect_if isect ();

    ray_scene_dispatcher #(
        .N_SPHERES (NS),
        .TIMEOUT   (TO),
        .THRESHOLD (4'd2),
        .BOUNDED   (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (resetN),
        .i_start     (start),
        .i_ray_p0    (rayP0),
        .i_ray_p1    (rayP1),
        .o_sph_addr  (sphAddr),
        .i_sph_data  (sphData),
        .isect       (isect),
        .o_busy      (busy),
        .o_done      (done),
        .o_hit       (hit),
        .o_hit_id    (hitId),
        .o_hit_point (hitPoint),
        .o_err       (err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Registered sphere table: data follows the address by one cycle.
    sphere_t romTable [NS];
    always @(posedge clk) sphData <= romTable[sphAddr];

    // Behavioural intersector: READY rises in the L-th cycle after the job pulse.
    logic  cfgCollide [NS];
    logic  cfgNever   [NS];
    vec3_t cfgPint0   [NS];
    vec3_t cfgPint1   [NS];
    int    cfgLatency = 10;
    logic [1:0] modelIdx = 2'd0;
    int    modelCnt = 0;
    logic  modelReady = 1'b0;
    int    enableCount = 0;

    always @(posedge clk) begin
        if (isect.enable) begin
            modelIdx    <= sphAddr;
            modelCnt    <= cfgLatency - 1;
            modelReady  <= (cfgLatency == 1) && !cfgNever[sphAddr];
            enableCount <= enableCount + 1;
        end else if (modelCnt > 0) begin
            modelCnt <= modelCnt - 1;
            if (modelCnt == 1 && !cfgNever[modelIdx]) modelReady <= 1'b1;
        end
    end

    assign isect.ready   = modelReady;
    assign isect.collide = cfgCollide[modelIdx];
    assign isect.pint0   = cfgPint0[modelIdx];
    assign isect.pint1   = cfgPint1[modelIdx];

    function automatic vec3_t mkVec(input int x, input int y, input int z);
        vec3_t v;
        v[0] = coord_t'(x);
        v[1] = coord_t'(y);
        v[2] = coord_t'(z);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clearScene(input int latency);
        cfgLatency = latency;
        for (int i = 0; i < NS; i++) begin
            cfgCollide[i] = 1'b0;
            cfgNever[i]   = 1'b0;
            cfgPint0[i]   = '0;
            cfgPint1[i]   = '0;
        end
    endtask

    task automatic setSphere(input int idx, input vec3_t a, input vec3_t b);
        cfgCollide[idx] = 1'b1;
        cfgPint0[idx]   = a;
        cfgPint1[idx]   = b;
    endtask

    // Runs one ray; returns the cycle of DONE (START-sampling cycle is 0) or -1.
    task automatic applyStimulus(input vec3_t p0, input vec3_t p1,
                                 output int doneCycle, output logic hitAtStart);
        @(negedge clk);
        rayP0 = p0;
        rayP1 = p1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        doneCycle  = -1;
        hitAtStart = 1'bx;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) hitAtStart = hit;
            if (done) begin
                doneCycle = c;
                break;
            end
        end
    endtask

    // Watches the FLUSH window following a reset release; optionally pokes START.
    task automatic flushCheck(input string tag, input logic pokeStart);
        int busyLow   = 0;
        int otherHigh = 0;
        int base      = enableCount;
        for (int k = 0; k < TO; k++) begin
            if (!busy) busyLow++;
            if (done || hit || hitId != 0 || hitPoint != 0 || err || isect.enable || sphAddr != 0)
                otherHigh++;
            if (pokeStart && k == 10) start = 1'b1;
            if (k == 11) start = 1'b0;
            @(negedge clk);
        end
        checkOutput({tag, "_busy_high"}, 64'(busyLow), 64'd0);
        checkOutput({tag, "_quiet"}, 64'(otherHigh), 64'd0);
        checkOutput({tag, "_idle_after"}, 64'(busy), 64'd0);
        checkOutput({tag, "_no_jobs"}, 64'(enableCount - base), 64'd0);
    endtask

    // Directed sequence of rays with hand-computed results.
    initial begin
        int   dc;
        int   base;
        logic hs;

        start  = 1'b0;
        resetN = 1'b0;
        rayP0  = '0;
        rayP1  = '0;
        for (int i = 0; i < NS; i++) romTable[i] = '{x: 16'(i * 100), y: 16'd1, z: 16'd2, r: 16'd10};
        clearScene(10);

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd1);
        checkOutput("rst_outputs", {done, hit, hitId, hitPoint, err, isect.enable, sphAddr}, 64'd0);
        resetN = 1'b1;
        flushCheck("flush0", 1'b1);

        // No collisions, L=10: 4 x 13 cycles + 1.
        clearScene(10);
        base = enableCount;
        applyStimulus(mkVec(0, 0, 0), mkVec(1, 2, 3), dc, hs);
        checkOutput("nohit_done_cycle", 64'(dc), 64'd53);
        checkOutput("nohit_hit", 64'(hit), 64'd0);
        checkOutput("nohit_err", 64'(err), 64'd0);
        checkOutput("nohit_jobs", 64'(enableCount - base), 64'd4);
        checkOutput("p1_latched", 64'(isect.p1), 64'(mkVec(1, 2, 3)));
        checkOutput("sphere_pass", isect.sphere, romTable[3]);
        checkOutput("bounded_thr", {isect.bounded, isect.threshold}, {59'd0, 1'b1, 4'd2});
        @(negedge clk);
        checkOutput("done_one_cycle", {done, busy}, 64'd0);

        // Tie between spheres 0 and 2 keeps sphere 0; L=2: 7+5+7+5+1.
        clearScene(2);
        setSphere(0, mkVec(7, 7, 7), mkVec(7, 7, 7));
        setSphere(2, mkVec(7, 7, 7), mkVec(7, 7, 7));
        applyStimulus(mkVec(0, 0, 0), mkVec(1, 1, 1), dc, hs);
        checkOutput("tie_done_cycle", 64'(dc), 64'd25);
        checkOutput("tie_hit", 64'(hit), 64'd1);
        checkOutput("tie_id", 64'(hitId), 64'd0);
        checkOutput("tie_point", 64'(hitPoint), 64'(mkVec(7, 7, 7)));

        // Negative origin: single hit at distance 200 along x.
        clearScene(1);
        setSphere(1, mkVec(100, 0, 0), mkVec(100, 0, 0));
        applyStimulus(mkVec(-100, 0, 0), mkVec(0, 0, 0), dc, hs);
        checkOutput("neg_hit", 64'(hit), 64'd1);
        checkOutput("neg_id", 64'(hitId), 64'd1);
        checkOutput("neg_point", 64'(hitPoint), 64'(mkVec(100, 0, 0)));

        // All three axes count: sphere 0 at d=81, sphere 1 at d=9.
        clearScene(3);
        setSphere(0, mkVec(0, 0, 9), mkVec(0, 9, 0));
        setSphere(1, mkVec(1, 2, 2), mkVec(1, 2, 2));
        applyStimulus(mkVec(0, 0, 0), mkVec(0, 0, 1), dc, hs);
        checkOutput("axes_id", 64'(hitId), 64'd1);
        checkOutput("axes_point", 64'(hitPoint), 64'(mkVec(1, 2, 2)));

        // Full-range span: pint0 is 65535 away, pint1 is 32768 away and wins.
        clearScene(2);
        setSphere(0, mkVec(32767, 0, 0), mkVec(0, 0, 0));
        setSphere(2, mkVec(0, 0, -32768), mkVec(32767, 0, 0));
        applyStimulus(mkVec(-32768, 0, 0), mkVec(0, 0, 0), dc, hs);
        checkOutput("wide_id", 64'(hitId), 64'd0);
        checkOutput("wide_point", 64'(hitPoint), 64'(mkVec(0, 0, 0)));

        // Sphere 2 never answers: abort after 64 WAIT cycles, sphere 3 skipped.
        clearScene(4);
        setSphere(0, mkVec(10, 0, 0), mkVec(10, 0, 0));
        setSphere(1, mkVec(3, 4, 0), mkVec(50, 0, 0));
        setSphere(3, mkVec(1, 0, 0), mkVec(1, 0, 0));
        cfgNever[2] = 1'b1;
        base = enableCount;
        applyStimulus(mkVec(0, 0, 0), mkVec(1, 0, 0), dc, hs);
        checkOutput("wdog_done_cycle", 64'(dc), 64'd85);
        checkOutput("wdog_err", 64'(err), 64'd1);
        checkOutput("wdog_hit", 64'(hit), 64'd1);
        checkOutput("wdog_id", 64'(hitId), 64'd1);
        checkOutput("wdog_point", 64'(hitPoint), 64'(mkVec(3, 4, 0)));
        checkOutput("wdog_jobs", 64'(enableCount - base), 64'd3);

        // Closest of two colliding spheres; ERR clears, old HIT held at start.
        clearScene(3);
        setSphere(1, mkVec(10, 0, 0), mkVec(30, 0, 0));
        setSphere(3, mkVec(5, 0, 0), mkVec(40, 0, 0));
        applyStimulus(mkVec(0, 0, 0), mkVec(1, 0, 0), dc, hs);
        checkOutput("near_hit_held", 64'(hs), 64'd1);
        checkOutput("near_done_cycle", 64'(dc), 64'd29);
        checkOutput("near_err", 64'(err), 64'd0);
        checkOutput("near_hit", 64'(hit), 64'd1);
        checkOutput("near_id", 64'(hitId), 64'd3);
        checkOutput("near_point", 64'(hitPoint), 64'(mkVec(5, 0, 0)));

        // Reset during WAIT aborts the ray and re-enters FLUSH.
        clearScene(10);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_in_wait", 64'(busy), 64'd1);
        resetN = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_busy", 64'(busy), 64'd1);
        checkOutput("mid_rst_outputs", {done, hit, hitId, hitPoint, err, isect.enable, sphAddr}, 64'd0);
        resetN = 1'b1;
        flushCheck("flush1", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout_global got=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
